// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types for the DMA bus arbiter: FSM states, register map and grant decode helper.
package dma_bus_arbiter_pkg;

    localparam int NUM_CH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [1:0] ADDR_MASK     = 2'd0;
    localparam logic [1:0] ADDR_MASK_BIT = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_RSVD     = 2'd3;

    // Active-low one-hot acknowledge pattern for a channel index.
    function automatic logic [3:0] ack_pattern(input logic [1:0] ch);
        ack_pattern = 4'hF;
        ack_pattern[ch] = 1'b0;
    endfunction

endpackage

// File: rtl/dma_priority_resolver.sv
// Combinational winner select over four requests; no latency, no backpressure.
// Build option DMA_ARB_ROTATING_PRIORITY_EN selects rotating priority, otherwise fixed (ch0 highest).
module dma_priority_resolver
    import dma_bus_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] winner,
    output logic       any
);

    assign any = |req;

`ifdef DMA_ARB_ROTATING_PRIORITY_EN
    logic       found;
    logic [1:0] idx;

    // Search begins just after the last served channel, wrapping modulo 4.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = last_grant + 2'(k + 1);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        winner = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) winner = 2'(k);
        end
    end
`endif

endmodule

// File: rtl/dma_bus_arbiter.sv
// Four-channel HOLD/HLDA bus arbiter with mask/status registers; outputs lag state by one clock.
// One transfer per hold; build option DMA_ARB_ROTATING_PRIORITY_EN enables rotating priority.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chip_select_n,
    input  logic              read_enable_n,
    input  logic              write_enable_n,
    input  logic [1:0]        address,
    input  logic [7:0]        data_bus_in,
    output logic [7:0]        data_bus_out,
    input  logic [NUM_CH-1:0] dma_request,
    input  logic              refresh_tick,
    output logic [NUM_CH-1:0] dma_acknowledge_n,
    output logic              hold_request,
    input  logic              hold_acknowledge,
    input  logic              transfer_done,
    output logic [1:0]        grant_channel,
    output logic              grant_active
);

    arb_state_t        state;
    logic [NUM_CH-1:0] mask;
    logic              refresh_pending;
    logic              tick_prev;
    logic              wr_prev;
    logic [1:0]        last_grant;
    logic [1:0]        grant_sel;
    logic [NUM_CH-1:0] req_raw;
    logic [NUM_CH-1:0] req;
    logic [1:0]        winner;
    logic              any_req;
    logic              wr_strobe;
    logic              wr_fire;
    logic              ch0_done;
    logic              unused_data;

    assign unused_data = ^data_bus_in[7:3];
    assign req_raw     = dma_request | {{(NUM_CH-1){1'b0}}, refresh_pending};
    assign req         = req_raw & ~mask;
    assign wr_strobe   = ~chip_select_n & ~write_enable_n;
    assign wr_fire     = wr_strobe & ~wr_prev;
    assign ch0_done    = (state == ST_GRANT) && transfer_done && (grant_sel == 2'd0);

    dma_priority_resolver u_resolver (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any_req)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask            <= '1;
            refresh_pending <= 1'b0;
            tick_prev       <= 1'b0;
            wr_prev         <= 1'b0;
        end else begin
            tick_prev <= refresh_tick;
            wr_prev   <= wr_strobe;
            // A new tick wins over a completing channel-0 grant in the same cycle.
            if (refresh_tick && !tick_prev) refresh_pending <= 1'b1;
            else if (ch0_done)              refresh_pending <= 1'b0;
            if (wr_fire) begin
                case (address)
                    ADDR_MASK:     mask <= data_bus_in[3:0];
                    ADDR_MASK_BIT: mask[data_bus_in[1:0]] <= data_bus_in[2];
                    default:       ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            last_grant        <= 2'd3;
            grant_sel         <= 2'd0;
            hold_request      <= 1'b0;
            dma_acknowledge_n <= '1;
            grant_channel     <= 2'd0;
            grant_active      <= 1'b0;
        end else begin
            // Outputs decode the state as it was before this edge.
            hold_request      <= (state == ST_HOLD) || (state == ST_GRANT);
            dma_acknowledge_n <= (state == ST_GRANT) ? ack_pattern(grant_sel) : '1;
            grant_active      <= (state == ST_GRANT);
            if (state == ST_GRANT) grant_channel <= grant_sel;
            case (state)
                ST_IDLE: if (any_req) state <= ST_HOLD;
                ST_HOLD: begin
                    if (hold_acknowledge) begin
                        if (any_req) begin
                            grant_sel <= winner;
                            state     <= ST_GRANT;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_GRANT: begin
                    if (transfer_done) begin
                        last_grant <= grant_sel;
                        state      <= ST_RELEASE;
                    end
                end
                ST_RELEASE: if (!hold_acknowledge) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_bus_out = 8'h00;
        if (!chip_select_n && !read_enable_n) begin
            case (address)
                ADDR_MASK:   data_bus_out = {req_raw, mask};
                ADDR_STATUS: data_bus_out = {state, 1'b0, refresh_pending, grant_active, 1'b0, grant_channel};
                ADDR_RSVD:   data_bus_out = 8'h00;
                default:     data_bus_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: register access, HOLD/HLDA handshake, priority, refresh and reset.
module tb_dma_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       chip_select_n, read_enable_n, write_enable_n;
    logic [1:0] address;
    logic [7:0] data_bus_in, data_bus_out;
    logic [3:0] dma_request, dma_acknowledge_n;
    logic       refresh_tick, hold_request, hold_acknowledge, transfer_done;
    logic [1:0] grant_channel;
    logic       grant_active;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    dma_bus_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .chip_select_n     (chip_select_n),
        .read_enable_n     (read_enable_n),
        .write_enable_n    (write_enable_n),
        .address           (address),
        .data_bus_in       (data_bus_in),
        .data_bus_out      (data_bus_out),
        .dma_request       (dma_request),
        .refresh_tick      (refresh_tick),
        .dma_acknowledge_n (dma_acknowledge_n),
        .hold_request      (hold_request),
        .hold_acknowledge  (hold_acknowledge),
        .transfer_done     (transfer_done),
        .grant_channel     (grant_channel),
        .grant_active      (grant_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        address = a; data_bus_in = d;
        chip_select_n = 1'b0; write_enable_n = 1'b0;
        @(negedge clock);
        chip_select_n = 1'b1; write_enable_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        address = a;
        chip_select_n = 1'b0; read_enable_n = 1'b0;
        #1 d = data_bus_out;
        chip_select_n = 1'b1; read_enable_n = 1'b1;
    endtask

    // Full handshake for one grant; next_req is applied with transfer_done.
    task automatic do_grant(input logic [1:0] ch, input logic [3:0] next_req);
        int n;
        logic [3:0] exp_ack;
        exp_ack = 4'hF;
        exp_ack[ch] = 1'b0;
        n = 0;
        while (!hold_request && n < 20) begin tick(1); n++; end
        check("grant_hold_req", hold_request, 1);
        hold_acknowledge = 1'b1;
        n = 0;
        while (dma_acknowledge_n == 4'hF && n < 10) begin tick(1); n++; end
        check("grant_ack", dma_acknowledge_n, exp_ack);
        check("grant_channel", grant_channel, ch);
        check("grant_active", grant_active, 1);
        transfer_done = 1'b1; dma_request = next_req;
        tick(1);
        transfer_done = 1'b0;
        n = 0;
        while (hold_request && n < 10) begin tick(1); n++; end
        check("grant_hold_drop", hold_request, 0);
        check("grant_ack_release", dma_acknowledge_n, 4'hF);
        hold_acknowledge = 1'b0;
        tick(2);
    endtask

    initial begin
        logic [7:0] rd;
        logic       seen;
        int         n;

        reset = 1'b1;
        chip_select_n = 1'b1; read_enable_n = 1'b1; write_enable_n = 1'b1;
        address = 2'd0; data_bus_in = 8'h00; dma_request = 4'h0;
        refresh_tick = 1'b0; hold_acknowledge = 1'b0; transfer_done = 1'b0;
        tick(2);
        check("rst_hold", hold_request, 0);
        check("rst_ack", dma_acknowledge_n, 4'hF);
        check("rst_gch", grant_channel, 0);
        check("rst_gact", grant_active, 0);
        check("rst_dout", data_bus_out, 8'h00);
        reset = 1'b0;
        tick(1);
        bus_read(2'd0, rd); check("rst_mask_rd", rd, 8'h0F);
        bus_read(2'd2, rd); check("rst_status_rd", rd, 8'h00);

        // Masked request must not raise HOLD.
        dma_request = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(1); seen = seen | hold_request; end
        check("masked_no_hold", seen, 0);
        bus_write(2'd0, 8'h00);
        check("hold_w0", hold_request, 0);
        tick(1); check("hold_w1", hold_request, 0);
        tick(1); check("hold_w2", hold_request, 1);
        bus_read(2'd2, rd); check("status_hold", rd, 8'h40);
        hold_acknowledge = 1'b1;
        tick(1); check("ack_m0", dma_acknowledge_n, 4'hF);
        tick(1); check("ack_m1", dma_acknowledge_n, 4'b1110);
        check("gact_m1", grant_active, 1);
        transfer_done = 1'b1; dma_request = 4'h0;
        tick(1); transfer_done = 1'b0;
        check("ack_k0", dma_acknowledge_n, 4'b1110);
        tick(1); check("ack_k1", dma_acknowledge_n, 4'hF);
        check("hold_k1", hold_request, 0);
        hold_acknowledge = 1'b0;
        tick(2);

        // Two requests, lower index first, one per hold.
        dma_request = 4'b1010;
        do_grant(2'd1, 4'b1000);
        do_grant(2'd3, 4'b0000);

`ifdef DMA_ARB_ROTATING_PRIORITY_EN
        dma_request = 4'b1111;
        do_grant(2'd0, 4'b1111);
        do_grant(2'd1, 4'b1111);
        do_grant(2'd2, 4'b1111);
        do_grant(2'd3, 4'b1111);
        do_grant(2'd0, 4'b0000);
`else
        dma_request = 4'b0011;
        do_grant(2'd0, 4'b0011);
        do_grant(2'd0, 4'b0011);
        do_grant(2'd0, 4'b0000);
`endif

        // Refresh tick requests channel 0.
        refresh_tick = 1'b1;
        tick(1);
        bus_read(2'd2, rd); check("refresh_pending_set", rd, 8'h10);
        do_grant(2'd0, 4'b0000);
        refresh_tick = 1'b0;
        bus_read(2'd2, rd); check("refresh_pending_clr", rd, 8'h00);

        // Request withdrawn during HOLD: straight to RELEASE.
        dma_request = 4'b0100;
        n = 0;
        while (!hold_request && n < 20) begin tick(1); n++; end
        check("wd_hold", hold_request, 1);
        dma_request = 4'b0000;
        hold_acknowledge = 1'b1;
        tick(1); check("wd_ack0", dma_acknowledge_n, 4'hF);
        tick(1); check("wd_ack1", dma_acknowledge_n, 4'hF);
        check("wd_hold_drop", hold_request, 0);
        bus_read(2'd2, rd); check("wd_status_release", rd, 8'hC0);
        hold_acknowledge = 1'b0;
        tick(2);
        bus_read(2'd2, rd); check("wd_status_idle", rd, 8'h00);

        bus_write(2'd1, 8'h06);
        bus_read(2'd0, rd); check("mask_bit_set", rd, 8'h04);
        bus_read(2'd3, rd); check("addr3_zero", rd, 8'h00);

        // Asynchronous reset while granted.
        dma_request = 4'b0001;
        n = 0;
        while (!hold_request && n < 20) begin tick(1); n++; end
        hold_acknowledge = 1'b1;
        n = 0;
        while (dma_acknowledge_n == 4'hF && n < 10) begin tick(1); n++; end
        check("pre_rst_ack", dma_acknowledge_n, 4'b1110);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ack", dma_acknowledge_n, 4'hF);
        check("async_rst_hold", hold_request, 0);
        dma_request = 4'h0;
        bus_read(2'd0, rd); check("async_rst_mask", rd, 8'h0F);
        @(negedge clock);
        reset = 1'b0; hold_acknowledge = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Four-channel bus-ownership arbiter for the XT chipset: collects DMA requests plus the memory-refresh tick from timer counter 1, requests the system bus from the CPU with a HOLD/HLDA handshake, and grants exactly one channel at a time with an active-low acknowledge. It sits beside the 8259/8253/8255 in the chipset I/O decode and exposes a small mask/status register file on the shared 8-bit data bus.

## Interface
- `NUM_CH`, 4: number of request channels; fixed at 4 in this revision.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `chip_select_n`  in  1  register-file select, active low.
- `read_enable_n`  in  1  I/O read strobe, active low.
- `write_enable_n`  in  1  I/O write strobe, active low.
- `address`  in  2  register index.
- `data_bus_in`  in  8  write data.
- `data_bus_out`  out  8  read data, combinational from registers.
- `dma_request`  in  4  level requests; bit 0 is highest priority at reset.
- `refresh_tick`  in  1  timer counter 1 output, level.
- `dma_acknowledge_n`  out  4  one-hot-low grant.
- `hold_request`  out  1  bus request to CPU.
- `hold_acknowledge`  in  1  bus released by CPU.
- `transfer_done`  in  1  one-cycle pulse from the transfer engine at the end of the granted bus cycle.
- `grant_channel`  out  2  index of the current or last granted channel.
- `grant_active`  out  1  high while any `dma_acknowledge_n` bit is low.

## Operation
- Registers: `mask[3:0]`, `refresh_pending`, `last_grant[1:0]`, and FSM state.
- Effective request: `req[i] = (dma_request[i] | (i==0 & refresh_pending)) & ~mask[i]`.
- `refresh_pending`:
  - Set on a rising edge of `refresh_tick`, detected with a 1-cycle registered copy.
  - Cleared when a channel-0 grant completes.
  - Set has priority when both happen in the same cycle.
- Writes take effect once per strobe, on the first clock where `~chip_select_n & ~write_enable_n` is seen after it was false. Address map:
  - Addr 0 write: `mask <= data_bus_in[3:0]`.
  - Addr 1 write: single-bit mask; `mask[data[1:0]] <= data[2]`.
  - Addr 0 read: `{req_raw[3:0], mask[3:0]}`, where `req_raw` is the unmasked request.
  - Addr 2 read: `{state[1:0], 1'b0, refresh_pending, grant_active, 1'b0, grant_channel}`.
  - Addr 3 reads 0. Writes to addr 2 and addr 3 are ignored.
  - `data_bus_out` is 0 when not selected or `read_enable_n` is high.
- FSM states: IDLE, HOLD, GRANT, RELEASE.
  - IDLE: if `|req`, go to HOLD.
  - HOLD: drive `hold_request=1` and wait for `hold_acknowledge=1`. In the cycle it is seen, resolve the winner from the current `req`, so a request arriving during HOLD can win. Then go to GRANT. If `req==0` in that cycle, go to RELEASE without granting.
  - GRANT: drive `dma_acknowledge_n[winner]=0` and `hold_request=1`. On `transfer_done`, update `last_grant` and go to RELEASE. Request withdrawal or masking during GRANT does not abort the grant.
  - RELEASE: acknowledges high and `hold_request=0`. Wait for `hold_acknowledge=0`, then go to IDLE.
- Exactly one transfer is made per hold, so the CPU gets the bus back between transfers.
- Reset values:
  - `mask=4'b1111`, `refresh_pending=0`, `last_grant=3`, state IDLE.
  - `hold_request=0`, `dma_acknowledge_n=4'b1111`, `grant_channel=0`, `grant_active=0`, `data_bus_out=0`.
- Reset mid-operation drops `hold_request` and all acknowledges immediately, because reset is asynchronous.

## Timing
- Request seen in IDLE at edge N: `hold_request` goes high after edge N+1.
- `hold_acknowledge` seen at edge M: acknowledge low after edge M+1.
- `transfer_done` at edge K: acknowledge and `hold_request` high/low after edge K+1.
- There is at least one IDLE cycle between consecutive grants.
- A register write is visible to arbitration on the cycle after the write edge.

## Configuration
- `DMA_ARB_ROTATING_PRIORITY_EN` defined: rotating priority. Search starts at `last_grant+1` modulo 4, so the just-served channel becomes lowest priority.
- Undefined: fixed priority, with channel 0 highest and channel 3 lowest. `last_grant` is still tracked for status.

## Structure
- Package `dma_bus_arbiter_pkg` holds:
  - the state enum (IDLE=0, HOLD=1, GRANT=2, RELEASE=3);
  - register address constants;
  - the `NUM_CH` default.
- Sub-module `dma_priority_resolver` is combinational:
  - inputs `req[3:0]` and `last_grant[1:0]`;
  - outputs `winner[1:0]` and `any`;
  - holds the rotate/fixed selection under the macro.

## Test plan
- After reset, `dma_request=4'b0001` with the mask still at reset → no `hold_request` for 20 cycles. Write addr 0 = 0x00 → `hold_request=1` two cycles later. `hold_acknowledge=1` → `dma_acknowledge_n=4'b1110`. `transfer_done` → `4'b1111` and `hold_request=0`.
- Requests 4'b1010 with mask 0 → channel 1 granted first, then channel 3 after the HLDA drop and a fresh HOLD.
- Rotating build: all four requests held high → grant sequence 0,1,2,3,0. Fixed build with requests 4'b0011 → grant sequence 0,0,0.
- `refresh_tick` rising edge with `dma_request=0` → channel 0 granted, `refresh_pending` is read as 1 at addr 2 before the grant and 0 after `transfer_done`.
- Request withdrawn during HOLD → on `hold_acknowledge`, FSM goes to RELEASE with no acknowledge pulse. Write addr 1 = 0x06 → `mask[2]=1` and the addr 0 read shows it.
- `reset` asserted during GRANT → `dma_acknowledge_n=4'b1111` and `hold_request=0` without waiting for a clock edge, and `mask` reads back 0x0F.
